// File: rtl/pc_unit.sv
// pc_unit -- 8-bit program counter with optional return-address stack.
//
// Purpose:
//   Holds the program counter and computes the next value from sequential
//   increment, relative branch, absolute jump, call and return controls.
//   Priority when several controls are asserted together:
//   ret > call > jump > branch > increment.
//
// Configuration macro:
//   PC_CALL_STACK_EN -- when defined, adds the return-address stack and the
//   call/ret push/pop behaviour. When undefined, call acts as jump, ret is
//   ignored, stk_empty is tied to 1, and stk_full/stk_err are tied to 0.
//
// Parameters:
//   RESET_PC     PC value loaded on reset
//   STACK_DEPTH  number of return-address entries (power of two, 2..8)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   advance enable; 0 holds all state
//   branch      in   relative branch (pc + 1 + branch_off)
//   branch_off  in   8-bit signed offset, already shifted by the upstream stage
//   jump        in   absolute jump to jump_addr
//   jump_addr   in   target for jump and call
//   call        in   push pc+1, then jump to jump_addr
//   ret         in   pop return address into pc
//   pc          out  registered program counter
//   stk_empty   out  stack holds no entries
//   stk_full    out  stack holds STACK_DEPTH entries
//   stk_err     out  sticky overflow/underflow flag, cleared only by reset
module pc_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       branch,
  input  logic [7:0] branch_off,
  input  logic       jump,
  input  logic [7:0] jump_addr,
  input  logic       call,
  input  logic       ret,
  output logic [7:0] pc,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_err
);

  logic [7:0] pc_inc;
  logic [7:0] pc_nxt;

  assign pc_inc = pc + 8'd1;

`ifdef PC_CALL_STACK_EN

  // sp counts entries 0..STACK_DEPTH, so it needs one bit more than the index.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [7:0]       stk_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_nxt;
  logic             err_nxt;
  logic             push;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign push_idx  = IDX_W'(sp);
  assign top_idx   = IDX_W'(sp - SP_W'(1));

  always_comb begin
    pc_nxt  = pc_inc;
    sp_nxt  = sp;
    err_nxt = stk_err;
    push    = 1'b0;
    if (ret) begin
      if (!stk_empty) begin
        pc_nxt = stk_mem[top_idx];
        sp_nxt = sp - SP_W'(1);
      end else begin
        // Underflow: fall back to a plain increment and flag it.
        err_nxt = 1'b1;
      end
    end else if (call) begin
      pc_nxt = jump_addr;
      if (!stk_full) begin
        push   = 1'b1;
        sp_nxt = sp + SP_W'(1);
      end else begin
        // Overflow: the jump still happens, the return address is lost.
        err_nxt = 1'b1;
      end
    end else if (jump) begin
      pc_nxt = jump_addr;
    end else if (branch) begin
      pc_nxt = pc_inc + branch_off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      sp      <= '0;
      stk_err <= 1'b0;
    end else if (en) begin
      pc      <= pc_nxt;
      sp      <= sp_nxt;
      stk_err <= err_nxt;
    end
  end

  // Entry contents are don't-care after reset, so the array has no reset;
  // the rst term only stops a push that coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && en && push) begin
      stk_mem[push_idx] <= pc_inc;
    end
  end

`else

  logic unused_ret;

  assign unused_ret = ret;
  assign stk_empty  = 1'b1;
  assign stk_full   = 1'b0;
  assign stk_err    = 1'b0;

  always_comb begin
    pc_nxt = pc_inc;
    if (call || jump) begin
      pc_nxt = jump_addr;
    end else if (branch) begin
      pc_nxt = pc_inc + branch_off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= pc_nxt;
    end
  end

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (RESET_PC = 8'h00, STACK_DEPTH = 4).
// Stack behaviour is exercised when PC_CALL_STACK_EN is defined; otherwise the
// tied-off flags and the call-as-jump / ignored-ret behaviour are checked.
module tb_pc_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic       branch;
  logic [7:0] branch_off;
  logic       jump;
  logic [7:0] jump_addr;
  logic       call;
  logic       ret;
  logic [7:0] pc;
  logic       stk_empty;
  logic       stk_full;
  logic       stk_err;

  int checks   = 0;
  int failures = 0;

  pc_unit #(.RESET_PC(8'h00), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .branch     (branch),
    .branch_off (branch_off),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .stk_empty  (stk_empty),
    .stk_full   (stk_full),
    .stk_err    (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       ret;
    logic       call;
    logic       jump;
    logic       branch;
    logic [7:0] off;
    logic [7:0] addr;
    logic [7:0] exp_pc;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic r, input logic c,
                              input logic j, input logic b,
                              input logic [7:0] off, input logic [7:0] addr,
                              input logic [7:0] p, input logic em,
                              input logic fu, input logic er);
    vec_t v;
    v.en = e; v.ret = r; v.call = c; v.jump = j; v.branch = b;
    v.off = off; v.addr = addr; v.exp_pc = p;
    v.exp_empty = em; v.exp_full = fu; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    en = v.en; ret = v.ret; call = v.call; jump = v.jump; branch = v.branch;
    branch_off = v.off; jump_addr = v.addr;
  endtask

  task automatic idle();
    en = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
    branch_off = 8'h00; jump_addr = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_pc", pc, 8'h00);
    chk("reset_empty", 8'(stk_empty), 8'h01);
    chk("reset_full", 8'(stk_full), 8'h00);
    chk("reset_err", 8'(stk_err), 8'h00);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].pc", tag, i), pc, tbl[i].exp_pc);
      chk($sformatf("%s[%0d].empty", tag, i), 8'(stk_empty), 8'(tbl[i].exp_empty));
      chk($sformatf("%s[%0d].full", tag, i), 8'(stk_full), 8'(tbl[i].exp_full));
      chk($sformatf("%s[%0d].err", tag, i), 8'(stk_err), 8'(tbl[i].exp_err));
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;

    // Wrap: 256 increments from reset return to 00.
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap[%0d]", k), pc, 8'(k));
    end
    idle();

    // Branch, jump, hold and priority among jump/branch (stack untouched).
    do_reset();
    tbl.delete();
    //            en ret cal jmp br  off    addr   pc     emp full err
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'h10, 8'h10, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'hFA, 8'h00, 8'h0B, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'hFE, 8'hFE, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'h04, 8'h00, 8'h03, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h77, 8'h04, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 8'h10, 8'h40, 8'h40, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'h7F, 8'h00, 8'hC0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'h80, 8'h00, 8'h41, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'h55, 8'h55, 1, 0, 0));
    run_table("basic");

    // Async reset between edges while pc = 55.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 8'h00);
    chk("async_rst_empty", 8'(stk_empty), 8'h01);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_hold", pc, 8'h00);

`ifdef PC_CALL_STACK_EN
    tbl.delete();
    //            en ret cal jmp br  off    addr   pc     emp full err
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'h20, 8'h20, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'h80, 8'h80, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h21, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'hA0, 8'hA0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'hA1, 8'hA1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'hA2, 8'hA2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'hA3, 8'hA3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'hA4, 8'hA4, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hA3, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hA2, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hA1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h22, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h23, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'hB0, 8'hB0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 8'h10, 8'hC0, 8'h24, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'hC0, 8'h24, 1, 0, 1));
    run_table("stack");

    // Underflow alone from a fresh reset.
    do_reset();
    ret = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    idle();
    chk("underflow_pc", pc, 8'h01);
    chk("underflow_err", 8'(stk_err), 8'h01);

    // Reset landing on a call edge abandons the push.
    do_reset();
    call = 1'b1; en = 1'b1; jump_addr = 8'h66;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("rst_on_call_pc", pc, 8'h00);
    chk("rst_on_call_empty", 8'(stk_empty), 8'h01);
`else
    tbl.delete();
    //            en ret cal jmp br  off    addr   pc     emp full err
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'h80, 8'h80, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h02, 8'h00, 8'h83, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h84, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 8'h10, 8'h90, 8'h90, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h90, 1, 0, 0));
    run_table("nostack");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 4, meaning the number of return-address stack entries (power of two, 2..8).
REQ-003 clk  input  1  system clock, rising-edge active; the block has one clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  advance enable; 0 holds all state.
REQ-006 branch  input  1  take relative branch this cycle.
REQ-007 branch_off  input  8  signed two's-complement offset, already shifted left by one by the upstream ShiftLeft stage.
REQ-008 jump  input  1  absolute jump this cycle.
REQ-009 jump_addr  input  8  absolute target for jump and call.
REQ-010 call  input  1  push return address and jump to jump_addr.
REQ-011 ret  input  1  pop return address into PC.
REQ-012 pc  output  8  current program counter, registered.
REQ-013 stk_empty  output  1  stack holds zero entries.
REQ-014 stk_full  output  1  stack holds STACK_DEPTH entries.
REQ-015 stk_err  output  1  sticky overflow/underflow flag.

Function
REQ-016 All state SHALL update only on a rising clk edge with en=1; with en=0, pc, the stack pointer, the stack contents and stk_err SHALL hold.
REQ-017 When several controls are asserted together, priority SHALL be ret > call > jump > branch > increment, and lower-priority controls SHALL be ignored.
REQ-018 Increment: pc SHALL become pc+1 modulo 256, so 8'hFF wraps to 8'h00.
REQ-019 Branch: pc SHALL become (pc + 1 + sign-extended branch_off) modulo 256, with no overflow flag.
REQ-020 Jump: pc SHALL become jump_addr.
REQ-021 Call when not full: pc+1 (mod 256) SHALL be pushed, the stack pointer SHALL increment, and pc SHALL become jump_addr.
REQ-022 Call when full: pc SHALL become jump_addr, the push SHALL be dropped with the stack unchanged, and stk_err SHALL set.
REQ-023 Ret when not empty: pc SHALL become the top entry and the stack pointer SHALL decrement.
REQ-024 Ret when empty: pc SHALL increment per REQ-018 and stk_err SHALL set.
REQ-025 Latency SHALL be one cycle: the new pc is visible after the same edge that samples the controls, with no combinational path from inputs to pc.
REQ-026 stk_empty and stk_full SHALL be decoded combinationally from the registered stack pointer only.
REQ-027 stk_err SHALL remain set until reset.

Reset
REQ-028 On rst high, and asynchronously, the block SHALL force pc=RESET_PC, stack pointer=0, stk_err=0, stk_empty=1 and stk_full=0.
REQ-029 Stack entry contents SHALL be don't-care after reset.
REQ-030 rst asserted mid-sequence, including during a call or ret cycle, SHALL abandon that operation.
REQ-031 The first update after rst deasserts SHALL occur on the first rising edge with en=1.

Configuration
REQ-032 Macro PC_CALL_STACK_EN, when defined, SHALL compile in the return-address stack and the call/ret behaviour of REQ-021 to REQ-024.
REQ-033 When PC_CALL_STACK_EN is undefined, the stack SHALL be absent and the following SHALL hold:
- call SHALL behave as jump;
- ret SHALL be ignored, with the priority order continuing from call;
- stk_empty SHALL be tied to 1, and stk_full and stk_err SHALL be tied to 0.

Verification
REQ-034 Wrap: reset, then en=1 for 256 cycles -> pc steps 00,01,...,FF,00.
REQ-035 Branch: pc=8'h10, branch=1, branch_off=8'hFA (-6) -> pc=8'h0B; then pc=8'hFE, branch_off=8'h04 -> pc=8'h03.
REQ-036 Call/ret (macro defined):
- pc=8'h20, call with jump_addr=8'h80 -> pc=8'h80, stk_empty=0;
- ret -> pc=8'h21, stk_empty=1.
REQ-037 Overflow/underflow (macro defined):
- five calls with STACK_DEPTH=4 -> stk_full=1 after the fourth call, and stk_err=1 after the fifth;
- five rets -> pops return the last four pushed values in reverse order, then the fifth ret increments pc.
REQ-038 Priority and hold:
- ret=call=jump=branch=1 with a non-empty stack -> pop wins;
- en=0 with call=1 -> no change.
REQ-039 Async reset: assert rst between clk edges while pc=8'h55 -> pc=RESET_PC immediately, without waiting for a clk edge.
